// File: rtl/icmp_echo_tx.sv
// ICMP echo reply transmitter: emits an 8-byte header with an adjusted checksum,
// then streams the stored request payload from the RX RAM through a small prefetch FIFO.
module icmp_echo_tx #(
  parameter int ADDR_WIDTH = 11,
  parameter int RAM_RD_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [15:0]           req_id,
  input  logic [15:0]           req_seq,
  input  logic [15:0]           req_cksum,
  input  logic [ADDR_WIDTH:0]   req_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [7:0]            ram_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  tx_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [15:0]             id_reg, seq_reg, ck_reg;
  logic [ADDR_WIDTH:0]     len_reg, rd_ptr_reg, pay_cnt_reg, len_m1;
  logic [2:0]              hdr_idx_reg;
  logic [ADDR_WIDTH-1:0]   addr_hold_reg;
  logic [RAM_RD_LAT-1:0]   vld_sr_reg;
  logic [7:0]              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        fifo_wr_reg, fifo_rd_reg;
  logic [CNT_W-1:0]        fifo_count_reg, in_flight;
  logic [OCC_W-1:0]        occupancy;
  logic [16:0]             ck_sum;
  logic [15:0]             ck_new;
  logic [7:0]              hdr_byte;
  logic                    req_fire, tx_fire, issue, push, pop;

  // Echo reply only changes the type byte 8->0, so fold +0x0800 in ones-complement.
  assign ck_sum    = {1'b0, req_cksum} + 17'h00800;
  assign ck_new    = ck_sum[15:0] + {15'd0, ck_sum[16]};
  assign req_ready = (state_reg == IDLE);
  assign req_fire  = req_valid & req_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign push      = vld_sr_reg[RAM_RD_LAT-1];
  assign pop       = (state_reg == PAY) & tx_fire;
  assign len_m1    = len_reg - ONE;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_RD_LAT; i++)
      in_flight = in_flight + CNT_W'(vld_sr_reg[i]);
  end

  // Reads in flight reserve FIFO slots so a landing byte always has room.
  assign occupancy   = OCC_W'(fifo_count_reg) + OCC_W'(in_flight);
  assign issue       = ((state_reg == HDR) || (state_reg == PAY)) &&
                       (rd_ptr_reg < len_reg) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign ram_rd_addr = issue ? rd_ptr_reg[ADDR_WIDTH-1:0] : addr_hold_reg;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx_reg)
      3'd2:    hdr_byte = ck_reg[15:8];
      3'd3:    hdr_byte = ck_reg[7:0];
      3'd4:    hdr_byte = id_reg[15:8];
      3'd5:    hdr_byte = id_reg[7:0];
      3'd6:    hdr_byte = seq_reg[15:8];
      3'd7:    hdr_byte = seq_reg[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    tx_done    = 1'b0;
    case (state_reg)
      IDLE: if (req_fire) state_next = HDR;
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        tx_last  = (hdr_idx_reg == 3'd7) && (len_reg == '0);
        if (tx_ready && hdr_idx_reg == 3'd7)
          state_next = (len_reg == '0) ? DONE : PAY;
      end
      PAY: begin
        tx_valid = (fifo_count_reg != '0);
        tx_data  = fifo_mem[fifo_rd_reg];
        tx_last  = tx_valid && (pay_cnt_reg == len_m1);
        if (tx_fire && tx_last) state_next = DONE;
      end
      DONE: begin
        tx_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      id_reg         <= '0;
      seq_reg        <= '0;
      ck_reg         <= '0;
      len_reg        <= '0;
      rd_ptr_reg     <= '0;
      pay_cnt_reg    <= '0;
      hdr_idx_reg    <= '0;
      addr_hold_reg  <= '0;
      vld_sr_reg     <= '0;
      fifo_wr_reg    <= '0;
      fifo_rd_reg    <= '0;
      fifo_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        id_reg      <= req_id;
        seq_reg     <= req_seq;
        ck_reg      <= ck_new;
        len_reg     <= req_len;
        rd_ptr_reg  <= '0;
        pay_cnt_reg <= '0;
        hdr_idx_reg <= '0;
      end
      if ((state_reg == HDR) && tx_fire) hdr_idx_reg <= hdr_idx_reg + 3'd1;
      if (pop) pay_cnt_reg <= pay_cnt_reg + ONE;
      if (issue) begin
        rd_ptr_reg    <= rd_ptr_reg + ONE;
        addr_hold_reg <= rd_ptr_reg[ADDR_WIDTH-1:0];
      end
      vld_sr_reg[0] <= issue;
      for (int i = 1; i < RAM_RD_LAT; i++) vld_sr_reg[i] <= vld_sr_reg[i-1];
      if (push) fifo_wr_reg <= fifo_wr_reg + PTR_W'(1);
      if (pop)  fifo_rd_reg <= fifo_rd_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_reg] <= ram_rd_data;
  end
endmodule
